// File: rtl/ifc_field_monitor.sv
// Multi-channel offset-field generator with a registered self-check and a
// fixed-length run window that reports pass/fail and a saturating mismatch count.
module ifc_field_monitor #(
    parameter int unsigned NCHAN       = 2,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NFIELDS     = 2,
    parameter int unsigned OFFSET_STEP = 100,
    parameter int unsigned RUN_CYCLES  = 20,
    localparam int unsigned CW         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [NCHAN*WIDTH-1:0]           chan_value,
    input  logic [NCHAN-1:0]                 chan_valid,
    input  logic [NCHAN-1:0]                 fault_inj,
    output logic [NCHAN*NFIELDS*WIDTH-1:0]   fields_out,
    output logic [NCHAN-1:0]                 fields_valid,
    output logic [7:0]                       err_count,
    output logic [CW-1:0]                    first_err_chan,
    output logic [1:0]                       state,
    output logic                             done,
    output logic                             pass
);
    localparam int unsigned TW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StPass = 2'd2,
        StFail = 2'd3
    } state_e;

    state_e                           state_q, state_d;
    logic [TW-1:0]                    cnt_q, cnt_d;
    logic [7:0]                       err_q, err_d;
    logic [CW-1:0]                    first_q, first_d;
    logic [NCHAN*NFIELDS*WIDTH-1:0]   fields_q, fields_d;
    logic [NCHAN-1:0]                 valid_q;
    logic [NCHAN*WIDTH-1:0]           value_q;
    logic [NCHAN-1:0]                 mism_q, mism_d;
    logic [31:0]                      n_mism;
    logic [31:0]                      err_sum;
    logic [7:0]                       err_sat;
    logic [CW-1:0]                    first_idx;

    // Offset is formed in 64 bits so wide fields see the full product before truncation.
    function automatic logic [WIDTH-1:0] field_offset(input int unsigned k);
        return WIDTH'(64'(k + 1) * 64'(OFFSET_STEP));
    endfunction

    always_comb begin
        fields_d = '0;
        for (int c = 0; c < NCHAN; c++) begin
            for (int k = 0; k < NFIELDS; k++) begin
                fields_d[(c*NFIELDS+k)*WIDTH +: WIDTH] = chan_value[c*WIDTH +: WIDTH]
                    + field_offset(k) + WIDTH'(fault_inj[c] && (k == 0));
            end
        end
    end

    // Re-derive every field from the delayed value copy; only valid channels can mismatch.
    always_comb begin
        mism_d = '0;
        for (int c = 0; c < NCHAN; c++) begin
            for (int k = 0; k < NFIELDS; k++) begin
                if (valid_q[c] && (fields_q[(c*NFIELDS+k)*WIDTH +: WIDTH]
                        != value_q[c*WIDTH +: WIDTH] + field_offset(k))) begin
                    mism_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_mism    = '0;
        first_idx = '0;
        for (int c = 0; c < NCHAN; c++) begin
            n_mism = n_mism + {31'b0, mism_q[c]};
        end
        for (int c = int'(NCHAN) - 1; c >= 0; c--) begin
            if (mism_q[c]) begin
                first_idx = CW'(c);
            end
        end
        err_sum = {24'b0, err_q} + n_mism;
        err_sat = (err_sum > 32'd255) ? 8'hFF : err_sum[7:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        unique case (state_q)
            StIdle, StPass, StFail: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            StRun: begin
                err_d = err_sat;
                // err_q is zero until the first counted mismatch, marking the capture cycle.
                if ((err_q == 8'd0) && (|mism_q)) begin
                    first_d = first_idx;
                end
                if (cnt_q == TW'(RUN_CYCLES - 1)) begin
                    state_d = (err_sat == 8'd0) ? StPass : StFail;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            err_q    <= '0;
            first_q  <= '0;
            fields_q <= '0;
            valid_q  <= '0;
            value_q  <= '0;
            mism_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            first_q  <= first_d;
            fields_q <= fields_d;
            valid_q  <= chan_valid;
            value_q  <= chan_value;
            mism_q   <= mism_d;
        end
    end

    assign fields_out     = fields_q;
    assign fields_valid   = valid_q;
    assign err_count      = err_q;
    assign first_err_chan = first_q;
    assign state          = state_q;
    assign done           = (state_q == StPass) || (state_q == StFail);
    assign pass           = (state_q == StPass);

endmodule

// File: tb/tb_ifc_field_monitor.sv
// Bench for ifc_field_monitor: stage-1 vector table plus scoreboarded run-window sequences.
module tb_ifc_field_monitor;
    localparam int RC = 20;

    logic         clk = 1'b0;
    logic         rst_n, start, start_s;
    logic [63:0]  chan_value;
    logic [1:0]   chan_valid, fault_inj, fault_s;
    logic [127:0] fields_out, fields_s;
    logic [1:0]   fields_valid, fvalid_s;
    logic [7:0]   err_count, err_s;
    logic [0:0]   first_err_chan, first_s;
    logic [1:0]   state, state_s;
    logic         done, pass, done_s, pass_s;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cyc  = 0;
    logic [31:0] base = 0;
    logic [1:0]  fsched [0:63];

    typedef struct { logic [127:0] f; logic [1:0] v; } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] v0, v1; logic [1:0] vld, flt; logic [127:0] ef;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    ifc_field_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chan_value(chan_value),
        .chan_valid(chan_valid), .fault_inj(fault_inj), .fields_out(fields_out),
        .fields_valid(fields_valid), .err_count(err_count),
        .first_err_chan(first_err_chan), .state(state), .done(done), .pass(pass)
    );

    ifc_field_monitor #(.RUN_CYCLES(300)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .chan_value(chan_value),
        .chan_valid(chan_valid), .fault_inj(fault_s), .fields_out(fields_s),
        .fields_valid(fvalid_s), .err_count(err_s),
        .first_err_chan(first_s), .state(state_s), .done(done_s), .pass(pass_s)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [31:0] v0, input logic [31:0] v1,
                                           input logic [1:0] flt);
        logic [31:0] a, b, c, d;
        a = v0 + 32'd100 + {31'b0, flt[0]};
        b = v0 + 32'd200;
        c = v1 + 32'd100 + {31'b0, flt[1]};
        d = v1 + 32'd200;
        return {d, c, b, a};
    endfunction

    task automatic drive(input logic [1:0] vld, input logic [1:0] flt);
        sb_t e;
        cyc++;
        chan_value = {base + cyc + 32'd2, base + cyc + 32'd1};
        chan_valid = vld;
        fault_inj  = flt;
        e.f = model(chan_value[31:0], chan_value[63:32], flt);
        e.v = vld;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("fields_out", fields_out, e.f);
            chk("fields_valid", {126'b0, fields_valid}, {126'b0, e.v});
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) fsched[i] = 2'b00;
    endtask

    // One full window; faults from fsched are driven at negedge i and count only if i <= RC-3.
    task automatic run_check(input string tag, input logic [1:0] vld, input int mid_start);
        int exp_err, exp_first;
        bit seen;
        logic [1:0] f;
        exp_err = 0; exp_first = 0; seen = 0;
        @(negedge clk);
        sb_check();
        start = 1'b1;
        drive(vld, 2'b00);
        for (int i = 0; i <= RC; i++) begin
            @(negedge clk);
            sb_check();
            start = (i == mid_start);
            if (i == 0) begin
                chk({tag, " state_run"}, {126'b0, state}, 128'd1);
                chk({tag, " err_clear"}, {120'b0, err_count}, 128'd0);
            end
            if (i == RC - 1) chk({tag, " still_run"}, {126'b0, state}, 128'd1);
            if (i == RC) begin
                chk({tag, " state_end"}, {126'b0, state}, (exp_err == 0) ? 128'd2 : 128'd3);
                chk({tag, " err_count"}, {120'b0, err_count}, 128'(exp_err));
                chk({tag, " first_err"}, {127'b0, first_err_chan}, 128'(exp_first));
                chk({tag, " done"}, {127'b0, done}, 128'd1);
                chk({tag, " pass"}, {127'b0, pass}, (exp_err == 0) ? 128'd1 : 128'd0);
            end
            f = (i < RC) ? fsched[i] : 2'b00;
            drive(vld, f);
            if (i <= RC - 3) begin
                for (int c = 0; c < 2; c++) begin
                    if (f[c] && vld[c]) begin
                        exp_err++;
                        if (!seen) begin seen = 1; exp_first = c; end
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'd0, 32'd0, 2'b11, 2'b00, {32'd200, 32'd100, 32'd200, 32'd100}};
        vecs[1] = '{32'hFFFF_FFF0, 32'hFFFF_FF9C, 2'b11, 2'b00,
                    {32'd100, 32'd0, 32'hB8, 32'h54}};
        vecs[2] = '{32'd5, 32'd7, 2'b10, 2'b01, {32'd207, 32'd107, 32'd205, 32'd106}};
        vecs[3] = '{32'hFFFF_FF9B, 32'd1234, 2'b01, 2'b10,
                    {32'd1434, 32'd1335, 32'h63, 32'hFFFF_FFFF}};
        vecs[4] = '{32'hFFFF_FF9B, 32'd0, 2'b00, 2'b01, {32'd200, 32'd100, 32'h63, 32'h0}};

        // Reset with random inputs
        rst_n = 1'b0; start = 1'b1; start_s = 1'b0; fault_s = 2'b00;
        chan_value = {$urandom, $urandom}; chan_valid = 2'($urandom); fault_inj = 2'($urandom);
        repeat (2) @(negedge clk);
        chk("rst state", {126'b0, state}, 128'd0);
        chk("rst fields", fields_out, 128'd0);
        chk("rst fvalid", {126'b0, fields_valid}, 128'd0);
        chk("rst err", {120'b0, err_count}, 128'd0);
        chk("rst first", {127'b0, first_err_chan}, 128'd0);
        chk("rst done_pass", {126'b0, done, pass}, 128'd0);
        rst_n = 1'b1; start = 1'b0; chan_valid = 2'b00; fault_inj = 2'b00;
        repeat (3) @(negedge clk);
        chk("idle hold", {126'b0, state}, 128'd0);

        // Stage-1 vector table
        for (int i = 0; i < 5; i++) begin
            sb_t e;
            chan_value = {vecs[i].v1, vecs[i].v0};
            chan_valid = vecs[i].vld;
            fault_inj  = vecs[i].flt;
            e.f = vecs[i].ef; e.v = vecs[i].vld;
            sb_q.push_back(e);
            @(negedge clk);
            sb_check();
        end
        fault_inj = 2'b00;

        clear_sched();
        run_check("clean", 2'b11, -1);
        fsched[5] = 2'b10; fsched[6] = 2'b10; fsched[7] = 2'b10;
        run_check("fault_ch1", 2'b11, -1);
        clear_sched();
        run_check("rerun", 2'b11, -1);
        fsched[5] = 2'b11; fsched[RC-3] = 2'b10; fsched[RC-2] = 2'b01; fsched[RC-1] = 2'b01;
        run_check("both_late", 2'b11, -1);
        clear_sched();
        fsched[4] = 2'b10;
        run_check("invalid_ch", 2'b01, -1);
        clear_sched();
        base = 32'hFFFF_FFE0 - cyc;
        run_check("wrap", 2'b11, -1);
        base = 0;

        // Reset in the middle of a run
        @(negedge clk); sb_check(); start = 1'b1; drive(2'b11, 2'b00);
        repeat (5) begin
            @(negedge clk); start = 1'b0; sb_check(); drive(2'b11, 2'b10);
        end
        @(negedge clk); sb_check();
        chk("pre_rst err", {120'b0, err_count}, 128'd3);
        rst_n = 1'b0; fault_inj = 2'b00;
        @(negedge clk);
        sb_q.delete();
        chk("midrst state", {126'b0, state}, 128'd0);
        chk("midrst err", {120'b0, err_count}, 128'd0);
        chk("midrst fields", fields_out, 128'd0);
        chk("midrst done", {127'b0, done}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst idle", {126'b0, state}, 128'd0);

        clear_sched();
        run_check("start_in_run", 2'b11, 7);

        // Saturation on the long-window instance
        @(negedge clk); sb_check(); start_s = 1'b1; fault_s = 2'b11; drive(2'b11, 2'b00);
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk); start_s = 1'b0; sb_check();
            if (i == 200) begin
                chk("sat mid err", {120'b0, err_s}, 128'd255);
                chk("sat mid state", {126'b0, state_s}, 128'd1);
            end
            if (i == 299) chk("sat last err", {120'b0, err_s}, 128'd255);
            if (i == 300) begin
                chk("sat state", {126'b0, state_s}, 128'd3);
                chk("sat err", {120'b0, err_s}, 128'd255);
                chk("sat first", {127'b0, first_s}, 128'd0);
                chk("sat pass", {126'b0, done_s, pass_s}, 128'd2);
            end
            drive(2'b11, 2'b00);
        end
        fault_s = 2'b00;
        @(negedge clk); sb_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
